// File: rtl/sdio_pkg.sv
// Shared SDIO CMD-line definitions: frame geometry, CRC7 polynomial and receiver states.
// Used by both the CMD receiver and the CMD transmitter.
package sdio_pkg;

  localparam int         FRAME_BITS   = 48;
  localparam logic [6:0] CRC7_POLY    = 7'h09;

  // Bit counter values: counter 0..39 covers the CRC-protected bits 47..8
  localparam int         CNT_W        = 6;
  localparam logic [5:0] CRC_LAST_CNT = 6'd39;
  localparam logic [5:0] END_CNT      = 6'(FRAME_BITS - 1);

  localparam int DIR_POS = 46;
  localparam int IDX_HI  = 45;
  localparam int IDX_LO  = 40;
  localparam int ARG_HI  = 39;
  localparam int ARG_LO  = 8;
  localparam int CRC_HI  = 7;
  localparam int CRC_LO  = 1;
  localparam int END_POS = 0;

  typedef enum logic {
    IDLE,
    RECV
  } rx_state_t;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdio_crc7_serial.sv
// Bit-serial CRC7 LFSR (x^7+x^3+1). Clearing while shifting seeds the register
// with the first bit, so a frame's start bit can be absorbed on the same edge.
module sdio_crc7_serial
  import sdio_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_shift_en,
  input  logic       i_bit_in,
  output logic [6:0] o_crc
);

  logic [6:0] r_crc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc <= 7'd0;
    end else if (i_clr) begin
      r_crc <= i_shift_en ? crc7_step(7'd0, i_bit_in) : 7'd0;
    end else if (i_shift_en) begin
      r_crc <= crc7_step(r_crc, i_bit_in);
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/sdio_cmd_rx.sv
// SDIO CMD-line receiver: deserialises 48-bit host frames, checks CRC7 and delivers
// them over valid/ready. Define SDIO_CMD_RX_STATS_EN to add good/CRC-error frame counters.
module sdio_cmd_rx
  import sdio_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_bit_stb,
  input  logic        i_cmd_in,
  output logic        o_cmd_valid,
  input  logic        i_cmd_ready,
  output logic [5:0]  o_cmd_index,
  output logic [31:0] o_cmd_arg,
  output logic        o_crc_err,
  output logic        o_end_err,
  output logic        o_dir_err,
  output logic        o_overrun
`ifdef SDIO_CMD_RX_STATS_EN
  ,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_crc_err_cnt
`endif
);

  rx_state_t  r_state, w_next_state;
  logic [CNT_W-1:0] r_bit_cnt;
  // Holds frame bits 46..0; the start bit (47) is always 0 and is not stored
  logic [FRAME_BITS-2:0] r_shift;
  logic       r_done;
  logic       w_start, w_shift, w_end, w_crc_clr, w_crc_shift;
  logic [6:0] w_crc;
  logic       w_load, w_crc_bad;

  sdio_crc7_serial u_crc (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clr      (w_crc_clr),
    .i_shift_en (w_crc_shift),
    .i_bit_in   (i_cmd_in),
    .o_crc      (w_crc)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_shift      = 1'b0;
    w_end        = 1'b0;
    w_crc_clr    = 1'b0;
    w_crc_shift  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_bit_stb && !i_cmd_in && i_enable) begin
          w_next_state = RECV;
          w_start      = 1'b1;
          w_crc_clr    = 1'b1;
          w_crc_shift  = 1'b1;
        end
      end
      RECV: begin
        if (!i_enable) begin
          w_next_state = IDLE;
        end else if (i_bit_stb) begin
          w_shift     = 1'b1;
          w_crc_shift = (r_bit_cnt <= CRC_LAST_CNT);
          if (r_bit_cnt == END_CNT) begin
            w_end        = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_end;
      if (w_start) begin
        r_bit_cnt <= 6'd1;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 6'd1;
        r_shift   <= {r_shift[FRAME_BITS-3:0], i_cmd_in};
      end
    end
  end

  // A completed frame is taken unless the previous one is still waiting unaccepted
  assign w_load    = r_done && (!o_cmd_valid || i_cmd_ready);
  assign w_crc_bad = (r_shift[CRC_HI:CRC_LO] != w_crc);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cmd_valid <= 1'b0;
      o_cmd_index <= '0;
      o_cmd_arg   <= '0;
      o_crc_err   <= 1'b0;
      o_end_err   <= 1'b0;
      o_dir_err   <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (w_load) begin
        o_cmd_valid <= 1'b1;
        o_cmd_index <= r_shift[IDX_HI:IDX_LO];
        o_cmd_arg   <= r_shift[ARG_HI:ARG_LO];
        o_crc_err   <= w_crc_bad;
        o_end_err   <= !r_shift[END_POS];
        o_dir_err   <= !r_shift[DIR_POS];
      end else if (o_cmd_valid && i_cmd_ready) begin
        o_cmd_valid <= 1'b0;
      end
      if (r_done && o_cmd_valid && !i_cmd_ready) o_overrun <= 1'b1;
    end
  end

`ifdef SDIO_CMD_RX_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_good_cnt    <= '0;
      o_crc_err_cnt <= '0;
    end else if (w_load) begin
      if (w_crc_bad) begin
        if (o_crc_err_cnt != 16'hFFFF) o_crc_err_cnt <= o_crc_err_cnt + 16'd1;
      end else begin
        if (o_good_cnt != 16'hFFFF) o_good_cnt <= o_good_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdio_cmd_rx.sv
// Directed bench for sdio_cmd_rx: known SD command frames sent one bit every 4 clocks,
// with hand-computed fields and error flags.
module tb_sdio_cmd_rx;

  localparam logic [47:0] CMD0      = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD8      = 48'h48_0000_01AA_87;
  localparam logic [47:0] CMD8BAD   = 48'h48_0000_01AA_89;
  localparam logic [47:0] CMD17     = 48'h51_0000_0000_55;
  localparam logic [47:0] CMD17END0 = 48'h51_0000_0000_54;
  localparam logic [47:0] CMD17DIR0 = 48'h11_0000_0000_55;

  logic        clk = 1'b0;
  logic        rst, enable, bitStb, cmdIn, cmdReady;
  logic        cmdValid, crcErr, endErr, dirErr, overrun;
  logic [5:0]  cmdIndex;
  logic [31:0] cmdArg;
`ifdef SDIO_CMD_RX_STATS_EN
  logic [15:0] goodCnt, crcErrCnt;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  sdio_cmd_rx dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_bit_stb     (bitStb),
    .i_cmd_in      (cmdIn),
    .o_cmd_valid   (cmdValid),
    .i_cmd_ready   (cmdReady),
    .o_cmd_index   (cmdIndex),
    .o_cmd_arg     (cmdArg),
    .o_crc_err     (crcErr),
    .o_end_err     (endErr),
    .o_dir_err     (dirErr),
    .o_overrun     (overrun)
`ifdef SDIO_CMD_RX_STATS_EN
    ,
    .o_good_cnt    (goodCnt),
    .o_crc_err_cnt (crcErrCnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends the first nBits bits MSB first; returns on the negedge right after the last strobe
  task automatic applyStimulus(input logic [47:0] frame, input int nBits);
    for (int i = 0; i < nBits; i++) begin
      @(negedge clk);
      bitStb = 1'b1;
      cmdIn  = frame[47-i];
      @(negedge clk);
      bitStb = 1'b0;
      cmdIn  = 1'b0;
      if (i != nBits - 1) repeat (2) @(negedge clk);
    end
  endtask

  task automatic checkFrame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                            input logic crcE, input logic endE, input logic dirE);
    checkOutput({tag, "_valid"}, 32'(cmdValid), 32'd1);
    checkOutput({tag, "_index"}, 32'(cmdIndex), 32'(idx));
    checkOutput({tag, "_arg"},   cmdArg, arg);
    checkOutput({tag, "_crcerr"}, 32'(crcErr), 32'(crcE));
    checkOutput({tag, "_enderr"}, 32'(endErr), 32'(endE));
    checkOutput({tag, "_direrr"}, 32'(dirErr), 32'(dirE));
  endtask

  task automatic acceptFrame(input string tag);
    @(negedge clk);
    cmdReady = 1'b1;
    @(negedge clk);
    cmdReady = 1'b0;
    checkOutput({tag, "_dropvalid"}, 32'(cmdValid), 32'd0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic sendAndAccept(input string tag, input logic [47:0] frame, input logic [5:0] idx,
                               input logic [31:0] arg, input logic crcE, input logic endE,
                               input logic dirE);
    applyStimulus(frame, 48);
    @(negedge clk);
    checkFrame(tag, idx, arg, crcE, endE, dirE);
    acceptFrame(tag);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; bitStb = 1'b0; cmdIn = 1'b0; cmdReady = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_valid",   32'(cmdValid), 32'd0);
    checkOutput("rst_index",   32'(cmdIndex), 32'd0);
    checkOutput("rst_arg",     cmdArg,        32'd0);
    checkOutput("rst_overrun", 32'(overrun),  32'd0);
    rst = 1'b0;

    // CMD0 with exact one-clock completion latency
    applyStimulus(CMD0, 48);
    checkOutput("cmd0_latency", 32'(cmdValid), 32'd0);
    @(negedge clk);
    checkFrame("cmd0", 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    acceptFrame("cmd0");

    sendAndAccept("cmd8",      CMD8,      6'd8,  32'h0000_01AA, 1'b0, 1'b0, 1'b0);
    sendAndAccept("cmd8bad",   CMD8BAD,   6'd8,  32'h0000_01AA, 1'b1, 1'b0, 1'b0);
    sendAndAccept("cmd17end0", CMD17END0, 6'd17, 32'd0,         1'b0, 1'b1, 1'b0);
    sendAndAccept("cmd17dir0", CMD17DIR0, 6'd17, 32'd0,         1'b1, 1'b0, 1'b1);

    // Second frame arrives while the first is unaccepted: first held, overrun set
    applyStimulus(CMD8, 48);
    @(negedge clk);
    applyStimulus(CMD0, 48);
    @(negedge clk);
    checkFrame("ovr_held", 6'd8, 32'h0000_01AA, 1'b0, 1'b0, 1'b0);
    checkOutput("ovr_flag", 32'(overrun), 32'd1);
    acceptFrame("ovr");
    checkOutput("ovr_sticky", 32'(overrun), 32'd1);
    doReset();
    checkOutput("ovr_rstclr", 32'(overrun), 32'd0);

    // Acceptance on the completion cycle: new frame replaces old, no overrun
    applyStimulus(CMD8, 48);
    @(negedge clk);
    applyStimulus(CMD0, 48);
    cmdReady = 1'b1;
    @(negedge clk);
    cmdReady = 1'b0;
    checkFrame("simul", 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("simul_overrun", 32'(overrun), 32'd0);
    acceptFrame("simul");

    // Abort a partial CMD8 by dropping enable, then a clean CMD0
    applyStimulus(CMD8, 20);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    applyStimulus(CMD0, 48);
    @(negedge clk);
    checkFrame("abort", 6'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    acceptFrame("abort");

    // Reset mid-frame with a frame pending, then a clean CMD17
    applyStimulus(CMD8, 48);
    @(negedge clk);
    applyStimulus(CMD17, 30);
    doReset();
    checkOutput("midrst_valid", 32'(cmdValid), 32'd0);
    checkOutput("midrst_index", 32'(cmdIndex), 32'd0);
    checkOutput("midrst_arg",   cmdArg,        32'd0);
    sendAndAccept("postrst", CMD17, 6'd17, 32'd0, 1'b0, 1'b0, 1'b0);

`ifdef SDIO_CMD_RX_STATS_EN
    doReset();
    checkOutput("stats_rst_good", 32'(goodCnt),   32'd0);
    checkOutput("stats_rst_bad",  32'(crcErrCnt), 32'd0);
    sendAndAccept("st1", CMD0,      6'd0,  32'd0,         1'b0, 1'b0, 1'b0);
    sendAndAccept("st2", CMD8BAD,   6'd8,  32'h0000_01AA, 1'b1, 1'b0, 1'b0);
    sendAndAccept("st3", CMD8,      6'd8,  32'h0000_01AA, 1'b0, 1'b0, 1'b0);
    sendAndAccept("st4", CMD17DIR0, 6'd17, 32'd0,         1'b1, 1'b0, 1'b1);
    sendAndAccept("st5", CMD17,     6'd17, 32'd0,         1'b0, 1'b0, 1'b0);
    checkOutput("stats_good", 32'(goodCnt),   32'd3);
    checkOutput("stats_bad",  32'(crcErrCnt), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
